regfile_2r1w: RTL and testbench

//   Parametrised register file: DEPTH words of WIDTH bits, one synchronous write port, two read ports.

---
 rtl/regfile_2r1w_pkg.sv | 12 +
 rtl/regfile_2r1w_mux_nway.sv | 21 ++
 rtl/regfile_2r1w.sv | 80 ++++++++
 tb/tb_regfile_2r1w.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_2r1w_pkg.sv
// Shared register-file defaults, also used by decode and hazard logic so that
// the zero-register and bypass behaviour stays consistent across the datapath.
package regfile_2r1w_pkg;

  localparam int RF_DEFAULT_WIDTH    = 32;
  localparam int RF_DEFAULT_DEPTH    = 32;
  localparam int RF_DEFAULT_ZERO_REG = 1;
  localparam int RF_DEFAULT_BYPASS   = 1;

  localparam int RF_NUM_READ_PORTS   = 2;

endpackage

// File: rtl/regfile_2r1w_mux_nway.sv
// Generic N:1 combinational select over a flattened bus of N words.
module mux_nway #(
  parameter int WIDTH = 32,
  parameter int N     = 32,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [WIDTH-1:0]   data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_i == SEL_W'(i)) begin
        data_o = data_i[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file: one synchronous write port, two registered read ports with
// optional write-to-read bypass and optional hardwired-zero entry 0.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH    = RF_DEFAULT_WIDTH,
  parameter int DEPTH    = RF_DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = RF_DEFAULT_ZERO_REG,
  parameter int BYPASS   = RF_DEFAULT_BYPASS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata2
);

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [DEPTH*WIDTH-1:0] mem_flat;
  logic [WIDTH-1:0]       rd1_mux;
  logic [WIDTH-1:0]       rd2_mux;
  logic [WIDTH-1:0]       rdata1_d;
  logic [WIDTH-1:0]       rdata2_d;
  logic [WIDTH-1:0]       rdata1_q;
  logic [WIDTH-1:0]       rdata2_q;
  logic                   wr_en;

  assign wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flatten
    assign mem_flat[gi*WIDTH +: WIDTH] = mem_q[gi];
  end

  mux_nway #(.WIDTH(WIDTH), .N(DEPTH)) u_rd1_mux (
    .data_i (mem_flat),
    .sel_i  (raddr1),
    .data_o (rd1_mux)
  );

  mux_nway #(.WIDTH(WIDTH), .N(DEPTH)) u_rd2_mux (
    .data_i (mem_flat),
    .sel_i  (raddr2),
    .data_o (rd2_mux)
  );

  // Zero override is applied last so it also wins over a bypassed write to entry 0.
  always_comb begin
    rdata1_d = rd1_mux;
    rdata2_d = rd2_mux;
    if ((BYPASS != 0) && we && (waddr == raddr1)) rdata1_d = wdata;
    if ((BYPASS != 0) && we && (waddr == raddr2)) rdata2_d = wdata;
    if ((ZERO_REG != 0) && (raddr1 == '0)) rdata1_d = '0;
    if ((ZERO_REG != 0) && (raddr2 == '0)) rdata2_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      if (wr_en) mem_q[waddr] <= wdata;
      if (re1)   rdata1_q <= rdata1_d;
      if (re2)   rdata2_q <= rdata2_d;
    end
  end

  assign rdata1 = rdata1_q;
  assign rdata2 = rdata2_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench: default build plus BYPASS=0, ZERO_REG=0 and an 8x4 build.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, re1, re2;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata;
  logic [31:0] d_rdata1, d_rdata2, b_rdata1, b_rdata2, z_rdata1, z_rdata2;

  logic        s_reset, s_we, s_re1, s_re2;
  logic [1:0]  s_waddr, s_raddr1, s_raddr2;
  logic [7:0]  s_wdata, s_rdata1, s_rdata2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_2r1w u_dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(d_rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(d_rdata2)
  );

  regfile_2r1w #(.BYPASS(0)) u_dut_nobyp (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(b_rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(b_rdata2)
  );

  regfile_2r1w #(.ZERO_REG(0)) u_dut_nozero (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(z_rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(z_rdata2)
  );

  regfile_2r1w #(.WIDTH(8), .DEPTH(4)) u_dut_small (
    .clk(clk), .reset(s_reset), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
    .re1(s_re1), .raddr1(s_raddr1), .rdata1(s_rdata1),
    .re2(s_re2), .raddr2(s_raddr2), .rdata2(s_rdata2)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_reset = 1'b1;
    we = 0; re1 = 0; re2 = 0; waddr = 0; raddr1 = 0; raddr2 = 0; wdata = 0;
    s_we = 0; s_re1 = 0; s_re2 = 0; s_waddr = 0; s_raddr1 = 0; s_raddr2 = 0; s_wdata = 0;
    cycle(); cycle();
    n_checks++;
    if (d_rdata1 !== 32'h0 || d_rdata2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: rdata1=%h rdata2=%h expected 0/0", d_rdata1, d_rdata2);
    end
    reset = 1'b0; s_reset = 1'b0;
    cycle();
    we = 1; waddr = 5; wdata = 32'hAEAEAE05;
    cycle();
    we = 0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    re1 = 1; re2 = 1; raddr1 = 5; raddr2 = 5;
    cycle();
    re1 = 0; re2 = 0;
    n_checks++;
    if (d_rdata1 !== 32'h0 || d_rdata2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_clears_mem: rdata1=%h rdata2=%h expected 0/0", d_rdata1, d_rdata2);
    end
    $display("test_reset: addr5 after reset rdata1=%h rdata2=%h", d_rdata1, d_rdata2);
  endtask

  task automatic test_fill_read();
    logic [31:0] exp1, exp2;
    for (int i = 1; i < 32; i++) begin
      we = 1; waddr = 5'(i); wdata = 32'hAEAEAE00 + 32'(i);
      cycle();
    end
    we = 0;
    for (int k = 0; k < 32; k++) begin
      re1 = 1; re2 = 1; raddr1 = 5'(k); raddr2 = 5'(31 - k);
      cycle();
      exp1 = (k == 0) ? 32'h0 : 32'hAEAEAE00 + 32'(k);
      exp2 = (k == 31) ? 32'h0 : 32'hAEAEAE00 + 32'(31 - k);
      n_checks++;
      if (d_rdata1 !== exp1 || d_rdata2 !== exp2) begin
        n_fail++;
        $display("FAIL fill_read k=%0d: rdata1=%h rdata2=%h expected %h/%h",
                 k, d_rdata1, d_rdata2, exp1, exp2);
      end
      $display("test_fill: raddr1=%0d rdata1=%h raddr2=%0d rdata2=%h", k, d_rdata1, 31 - k, d_rdata2);
    end
    re1 = 0; re2 = 0;
  endtask

  task automatic test_bypass();
    we = 1; waddr = 6; wdata = 32'h12345678;
    re1 = 1; raddr1 = 6; re2 = 1; raddr2 = 6;
    cycle();
    we = 0;
    n_checks++;
    if (d_rdata1 !== 32'h12345678 || d_rdata2 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL bypass_on: rdata1=%h rdata2=%h expected 12345678/12345678", d_rdata1, d_rdata2);
    end
    n_checks++;
    if (b_rdata1 !== 32'hAEAEAE06 || b_rdata2 !== 32'hAEAEAE06) begin
      n_fail++;
      $display("FAIL bypass_off_old: rdata1=%h rdata2=%h expected aeaeae06/aeaeae06", b_rdata1, b_rdata2);
    end
    cycle();
    n_checks++;
    if (b_rdata1 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL bypass_off_next: rdata1=%h expected 12345678", b_rdata1);
    end
    re1 = 0; re2 = 0;
    $display("test_bypass: bypass rdata1=%h no-bypass rdata1=%h", d_rdata1, b_rdata1);
  endtask

  task automatic test_zero_reg();
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF;
    cycle();
    we = 0; re1 = 1; raddr1 = 0;
    cycle();
    n_checks++;
    if (d_rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_reg_on: rdata1=%h expected 0", d_rdata1);
    end
    n_checks++;
    if (z_rdata1 !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL zero_reg_off: rdata1=%h expected ffffffff", z_rdata1);
    end
    we = 1; waddr = 0; wdata = 32'h0000BEEF;
    cycle();
    we = 0;
    n_checks++;
    if (d_rdata1 !== 32'h0 || z_rdata1 !== 32'h0000BEEF) begin
      n_fail++;
      $display("FAIL zero_reg_bypass: zero=%h nozero=%h expected 0/0000beef", d_rdata1, z_rdata1);
    end
    re1 = 0;
    $display("test_zero_reg: zero rdata1=%h nozero rdata1=%h", d_rdata1, z_rdata1);
  endtask

  task automatic test_hold();
    re1 = 1; raddr1 = 28;
    cycle();
    n_checks++;
    if (d_rdata1 !== 32'hAEAEAE1C) begin
      n_fail++;
      $display("FAIL hold_load: rdata1=%h expected aeaeae1c", d_rdata1);
    end
    re1 = 0; raddr1 = 3;
    we = 1; waddr = 28; wdata = 32'h0BADF00D;
    cycle();
    we = 0;
    cycle();
    n_checks++;
    if (d_rdata1 !== 32'hAEAEAE1C) begin
      n_fail++;
      $display("FAIL hold_keep: rdata1=%h expected aeaeae1c", d_rdata1);
    end
    $display("test_hold: rdata1=%h", d_rdata1);
  endtask

  task automatic test_small();
    s_we = 1; s_waddr = 3; s_wdata = 8'hA5;
    cycle();
    s_we = 0; s_re1 = 1; s_re2 = 1; s_raddr1 = 3; s_raddr2 = 3;
    cycle();
    n_checks++;
    if (s_rdata1 !== 8'hA5 || s_rdata2 !== 8'hA5) begin
      n_fail++;
      $display("FAIL small_rw: rdata1=%h rdata2=%h expected a5/a5", s_rdata1, s_rdata2);
    end
    s_raddr2 = 0;
    cycle();
    n_checks++;
    if (s_rdata1 !== 8'hA5 || s_rdata2 !== 8'h00) begin
      n_fail++;
      $display("FAIL small_zero: rdata1=%h rdata2=%h expected a5/00", s_rdata1, s_rdata2);
    end
    s_raddr2 = 3;
    cycle();
    #2 s_reset = 1'b1;
    #1;
    n_checks++;
    if (s_rdata1 !== 8'h00 || s_rdata2 !== 8'h00) begin
      n_fail++;
      $display("FAIL small_async_reset: rdata1=%h rdata2=%h expected 00/00", s_rdata1, s_rdata2);
    end
    cycle();
    s_reset = 1'b0;
    cycle();
    n_checks++;
    if (s_rdata1 !== 8'h00 || s_rdata2 !== 8'h00) begin
      n_fail++;
      $display("FAIL small_mem_cleared: rdata1=%h rdata2=%h expected 00/00", s_rdata1, s_rdata2);
    end
    s_re1 = 0; s_re2 = 0;
    $display("test_small: after reset rdata1=%h rdata2=%h", s_rdata1, s_rdata2);
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_bypass();
    test_zero_reg();
    test_hold();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
